sync_fifo_pflag: RTL and testbench

- Single-clock, parametrised synchronous FIFO. It is the next-generation replacement for the fixed 18-bit / 1K-deep FIFO mode of the TDP18K primitive.
- Generalised data width and depth. Internal register-array storage.
- Adds features the 18K primitive lacks: occupancy count output, sticky overrun/underrun flags, synchronous flush with defined priority, and a documented read/write collision rule.
- Sits between fabric logic and the BRAM wrappers wherever a shallow, flag-rich, single-clock FIFO is needed.

---
 rtl/sync_fifo_pkg.sv | 25 ++
 rtl/sync_fifo_flag_gen.sv | 60 ++++++
 rtl/sync_fifo_pflag.sv | 100 ++++++++++
 tb/tb_sync_fifo_pflag.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/sync_fifo_pkg.sv
// Shared definitions for the flag-rich single-clock FIFO: flag bus layout and
// count-width helper.
package sync_fifo_pkg;

  localparam int unsigned FLAG_W = 8;

  // Flag bus order {FULL, FMO, FWM, OVERRUN, EMPTY, EPO, EWM, UNDERRUN}
  localparam int unsigned FLAG_UNDERRUN = 0;
  localparam int unsigned FLAG_EWM      = 1;
  localparam int unsigned FLAG_EPO      = 2;
  localparam int unsigned FLAG_EMPTY    = 3;
  localparam int unsigned FLAG_OVERRUN  = 4;
  localparam int unsigned FLAG_FWM      = 5;
  localparam int unsigned FLAG_FMO      = 6;
  localparam int unsigned FLAG_FULL     = 7;

  localparam logic [FLAG_W-1:0] FLAGS_RST =
    FLAG_W'((32'd1 << FLAG_EMPTY) | (32'd1 << FLAG_EWM));

  // Bits needed to hold 0..depth inclusive
  function automatic int unsigned clog2p1(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/sync_fifo_flag_gen.sv
// Occupancy counter and the eight registered status flags, all derived from
// the next count so they change on the same edge as the count.
module sync_fifo_flag_gen
  import sync_fifo_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned UPAE       = 2,
  parameter int unsigned UPAF       = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              wr_req,
  input  logic              rd_req,
  input  logic              wr_ok,
  input  logic              rd_ok,
  output logic [ADDR_WIDTH:0] count,
  output logic [FLAG_W-1:0] flags
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
  localparam int unsigned CW    = clog2p1(DEPTH);

  logic [CW-1:0]     count_q, count_next;
  logic [FLAG_W-1:0] flags_q, flags_next;

  always_comb begin
    count_next = count_q;
    flags_next = flags_q;
    if (flush) begin
      count_next = '0;
      flags_next = FLAGS_RST;
    end else begin
      count_next = count_q + CW'(wr_ok) - CW'(rd_ok);
      flags_next[FLAG_EMPTY]    = (count_next == '0);
      flags_next[FLAG_EPO]      = (count_next == CW'(1));
      flags_next[FLAG_EWM]      = (count_next <= CW'(UPAE));
      flags_next[FLAG_FULL]     = (count_next == CW'(DEPTH));
      flags_next[FLAG_FMO]      = (count_next == CW'(DEPTH - 1));
      flags_next[FLAG_FWM]      = (count_next >= CW'(DEPTH - UPAF));
      // Sticky error flags use the registered full/empty seen by the request
      flags_next[FLAG_OVERRUN]  = flags_q[FLAG_OVERRUN] | (wr_req & flags_q[FLAG_FULL]);
      flags_next[FLAG_UNDERRUN] = flags_q[FLAG_UNDERRUN] | (rd_req & flags_q[FLAG_EMPTY]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
      flags_q <= FLAGS_RST;
    end else begin
      count_q <= count_next;
      flags_q <= flags_next;
    end
  end

  assign count = count_q;
  assign flags = flags_q;

endmodule

// File: rtl/sync_fifo_pflag.sv
// Parametrised single-clock FIFO with occupancy count, watermark flags,
// sticky overrun/underrun and synchronous flush; 1-cycle registered read.
module sync_fifo_pflag
  import sync_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 18,
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned UPAE       = 2,
  parameter int unsigned UPAF       = 3
) (
  input  logic                  CLK_i,
  input  logic                  RST_i,
  input  logic                  FLUSH_i,
  input  logic                  WEN_i,
  input  logic [DATA_WIDTH-1:0] WDATA_i,
  input  logic                  REN_i,
  output logic [DATA_WIDTH-1:0] RDATA_o,
  output logic [ADDR_WIDTH:0]   COUNT_o,
  output logic                  EMPTY_o,
  output logic                  EPO_o,
  output logic                  EWM_o,
  output logic                  UNDERRUN_o,
  output logic                  FULL_o,
  output logic                  FMO_o,
  output logic                  FWM_o,
  output logic                  OVERRUN_o
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  if (ADDR_WIDTH < 2 || ADDR_WIDTH > 12) begin : g_bad_aw
    $error("sync_fifo_pflag: ADDR_WIDTH %0d outside 2..12", ADDR_WIDTH);
  end
  if (UPAE >= DEPTH) begin : g_bad_upae
    $error("sync_fifo_pflag: UPAE %0d must be below DEPTH %0d", UPAE, DEPTH);
  end
  if (UPAF >= DEPTH) begin : g_bad_upaf
    $error("sync_fifo_pflag: UPAF %0d must be below DEPTH %0d", UPAF, DEPTH);
  end

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wptr, rptr;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [FLAG_W-1:0]     flags;
  logic                  wr_ok, rd_ok;

  // Flush wins over both requests; full/empty gating makes same-address
  // read and write in one cycle impossible.
  assign wr_ok = WEN_i & ~flags[FLAG_FULL]  & ~FLUSH_i;
  assign rd_ok = REN_i & ~flags[FLAG_EMPTY] & ~FLUSH_i;

  always_ff @(posedge CLK_i or posedge RST_i) begin
    if (RST_i) begin
      wptr    <= '0;
      rptr    <= '0;
      rdata_q <= '0;
    end else if (FLUSH_i) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (wr_ok) wptr <= wptr + ADDR_WIDTH'(1);
      if (rd_ok) begin
        rptr    <= rptr + ADDR_WIDTH'(1);
        rdata_q <= mem[rptr];
      end
    end
  end

  // Storage is intentionally not reset
  always_ff @(posedge CLK_i) begin
    if (wr_ok) mem[wptr] <= WDATA_i;
  end

  sync_fifo_flag_gen #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .UPAE      (UPAE),
    .UPAF      (UPAF)
  ) u_flag_gen (
    .clk   (CLK_i),
    .rst   (RST_i),
    .flush (FLUSH_i),
    .wr_req(WEN_i),
    .rd_req(REN_i),
    .wr_ok (wr_ok),
    .rd_ok (rd_ok),
    .count (COUNT_o),
    .flags (flags)
  );

  assign RDATA_o    = rdata_q;
  assign EMPTY_o    = flags[FLAG_EMPTY];
  assign EPO_o      = flags[FLAG_EPO];
  assign EWM_o      = flags[FLAG_EWM];
  assign UNDERRUN_o = flags[FLAG_UNDERRUN];
  assign FULL_o     = flags[FLAG_FULL];
  assign FMO_o      = flags[FLAG_FMO];
  assign FWM_o      = flags[FLAG_FWM];
  assign OVERRUN_o  = flags[FLAG_OVERRUN];

endmodule

// File: tb/tb_sync_fifo_pflag.sv
// Directed bench for sync_fifo_pflag: vector table for fill/drain/collisions,
// plus hand sequences for streaming wrap, flush and async reset.
module tb_sync_fifo_pflag;

  localparam int unsigned DW = 18;
  localparam int unsigned AW = 4;

  logic          clk = 1'b0;
  logic          rst, flush, wen, ren;
  logic [DW-1:0] wdata;
  logic [DW-1:0] rdata;
  logic [AW:0]   count;
  logic          empty, epo, ewm, underrun, full, fmo, fwm, overrun;

  sync_fifo_pflag #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .UPAE(2), .UPAF(3)) dut (
    .CLK_i(clk), .RST_i(rst), .FLUSH_i(flush), .WEN_i(wen), .WDATA_i(wdata),
    .REN_i(ren), .RDATA_o(rdata), .COUNT_o(count), .EMPTY_o(empty), .EPO_o(epo),
    .EWM_o(ewm), .UNDERRUN_o(underrun), .FULL_o(full), .FMO_o(fmo), .FWM_o(fwm),
    .OVERRUN_o(overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          wen;
    logic          ren;
    logic [DW-1:0] wdata;
    int            cnt;
    logic [DW-1:0] rd;
    bit            ovr;
    bit            udr;
  } vec_t;

  vec_t          vecs[$];
  int            n_checks = 0;
  int            n_fail   = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] last_rd;

  // Expected flag bus {FULL,FMO,FWM,OVR,EMPTY,EPO,EWM,UDR} for DEPTH=16, UPAE=2, UPAF=3
  function automatic logic [7:0] flags_for(input int c, input bit ovr, input bit udr);
    return {c == 16, c == 15, c >= 13, ovr, c == 0, c == 1, c <= 2, udr};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_state(input string name, input int cnt, input logic [DW-1:0] rd,
                             input bit ovr, input bit udr);
    chk({name, " count"}, 32'(count), 32'(cnt));
    chk({name, " rdata"}, 32'(rdata), 32'(rd));
    chk({name, " flags"},
        32'({full, fmo, fwm, overrun, empty, epo, ewm, underrun}),
        32'(flags_for(cnt, ovr, udr)));
  endtask

  task automatic step(input logic w, input logic r, input logic f, input logic [DW-1:0] d);
    wen = w; ren = r; flush = f; wdata = d;
    @(posedge clk);
    #1;
    wen = 1'b0; ren = 1'b0; flush = 1'b0;
  endtask

  function automatic vec_t mk(input logic w, input logic r, input logic [DW-1:0] d,
                              input int c, input logic [DW-1:0] rd, input bit o, input bit u);
    vec_t v;
    v.wen = w; v.ren = r; v.wdata = d; v.cnt = c; v.rd = rd; v.ovr = o; v.udr = u;
    return v;
  endfunction

  initial begin
    // Fill 1..16, overrun write, full collision, drain, empty read, empty collision
    for (int i = 1; i <= 16; i++) vecs.push_back(mk(1, 0, DW'(i), i, '0, 0, 0));
    vecs.push_back(mk(1, 0, 18'h00011, 16, '0, 1, 0));
    vecs.push_back(mk(1, 1, 18'h3FFFF, 15, 18'h00001, 1, 0));
    for (int i = 2; i <= 16; i++) vecs.push_back(mk(0, 1, '0, 16 - i, DW'(i), 1, 0));
    vecs.push_back(mk(0, 1, '0, 0, 18'h00010, 1, 1));
    vecs.push_back(mk(1, 1, 18'h3ABCD, 1, 18'h00010, 1, 1));
    vecs.push_back(mk(0, 1, '0, 0, 18'h3ABCD, 1, 1));

    rst = 1'b1; flush = 1'b0; wen = 1'b0; ren = 1'b0; wdata = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check_state("reset", 0, '0, 0, 0);
    step(0, 0, 0, '0);
    check_state("idle", 0, '0, 0, 0);

    foreach (vecs[i]) begin
      step(vecs[i].wen, vecs[i].ren, 1'b0, vecs[i].wdata);
      check_state($sformatf("vec%0d", i), vecs[i].cnt, vecs[i].rd, vecs[i].ovr, vecs[i].udr);
    end

    // Streaming: 8 deep, then 40 simultaneous read/write cycles wrapping the pointers
    for (int k = 0; k < 8; k++) begin
      step(1, 0, 0, DW'(32'h100 + k));
      exp_q.push_back(DW'(32'h100 + k));
      chk($sformatf("fill%0d count", k), 32'(count), 32'(k + 1));
    end
    last_rd = 18'h3ABCD;
    for (int k = 0; k < 40; k++) begin
      step(1, 1, 0, DW'(32'h200 + k));
      exp_q.push_back(DW'(32'h200 + k));
      last_rd = exp_q.pop_front();
      chk($sformatf("stream%0d rdata", k), 32'(rdata), 32'(last_rd));
      chk($sformatf("stream%0d count", k), 32'(count), 32'd8);
    end

    // Flush at count 10 with both sticky flags set and a write pending
    step(1, 0, 0, 18'h00AA1);
    step(1, 0, 0, 18'h00AA2);
    check_state("pre_flush", 10, last_rd, 1, 1);
    step(1, 0, 1, 18'h2DEAD);
    check_state("flush", 0, last_rd, 0, 0);
    step(0, 1, 0, '0);
    check_state("flush_empty_rd", 0, last_rd, 0, 1);
    step(1, 0, 0, 18'h00555);
    step(0, 1, 0, '0);
    check_state("post_flush_rd", 0, 18'h00555, 0, 1);

    // Async reset mid-burst: outputs clear before the next rising edge
    step(1, 0, 0, 18'h00111);
    step(1, 0, 0, 18'h00222);
    wen = 1'b1; wdata = 18'h00333;
    #2 rst = 1'b1;
    #1;
    check_state("async_rst", 0, '0, 0, 0);
    @(posedge clk);
    #1 rst = 1'b0; wen = 1'b0;
    check_state("rst_hold", 0, '0, 0, 0);
    step(1, 0, 0, 18'h0AAAA);
    check_state("post_rst_wr", 1, '0, 0, 0);
    step(0, 1, 0, '0);
    check_state("post_rst_rd", 0, 18'h0AAAA, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
